// File: rtl/gsim_result_buffer.sv
// Ping-pong result buffer between the Gauss-Seidel solver and a back-pressuring consumer.
// Captures 16-word Q16.16 frames into two banks and replays them over a ready/valid stream.
module gsim_result_buffer #(
    parameter int N_WORDS  = 16,
    parameter int DW       = 32,
    parameter bit ROUND_EN = 1'b0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       sol_valid,
    input  logic [DW-1:0]              sol_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DW-1:0]              out_data,
    output logic [$clog2(N_WORDS)-1:0] out_idx,
    output logic                       out_last,
    output logic [7:0]                 frame_cnt,
    output logic                       overflow,
    output logic                       frame_err
);

    localparam int IW = $clog2(N_WORDS);
    localparam logic [IW-1:0] PTR_ZERO = {IW{1'b0}};
    localparam logic [IW-1:0] PTR_ONE  = {{(IW-1){1'b0}}, 1'b1};
    localparam logic [IW-1:0] PTR_LAST = IW'(N_WORDS - 1);

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_FILL = 2'd1,
        W_DROP = 2'd2
    } wstate_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_SEND = 1'b1
    } rstate_t;

    // Round-half-up of a Q16.16 word to an integer, saturated to DW bits.
    function automatic logic [DW-1:0] round_q16(input logic [DW-1:0] word);
        logic signed [DW:0] sum;
        logic signed [DW:0] shifted;
        sum     = $signed({word[DW-1], word}) + $signed({{(DW-15){1'b0}}, 16'h8000});
        shifted = sum >>> 5'd16;
        if (shifted[DW] != shifted[DW-1]) begin
            round_q16 = shifted[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        end else begin
            round_q16 = shifted[DW-1:0];
        end
    endfunction

    logic [DW-1:0] r_mem [0:1][0:N_WORDS-1];
    logic [1:0]    r_full;

    wstate_t       r_wstate;
    wstate_t       w_wstate_nxt;
    logic          r_cap_en;
    logic [IW-1:0] r_wr_ptr;
    logic [IW-1:0] w_wr_ptr_nxt;
    logic          r_wr_bank;
    logic          w_we;
    logic          w_set_full;
    logic          w_ferr;
    logic          w_ovf_set;
    logic          r_frame_err;
    logic          r_overflow;

    rstate_t       r_rstate;
    rstate_t       w_rstate_nxt;
    logic          r_rd_bank;
    logic          w_rd_bank_nxt;
    logic [IW-1:0] r_rd_ptr;
    logic          w_xfer;
    logic          w_load;
    logic          w_load_bank;
    logic [IW-1:0] w_load_ptr;
    logic          w_clr_full;
    logic          w_cnt_inc;
    logic          w_valid_nxt;
    logic          r_out_valid;
    logic [DW-1:0] r_out_data;
    logic          r_out_last;
    logic [7:0]    r_frame_cnt;
    logic [DW-1:0] w_rd_word;
    logic [DW-1:0] w_fmt_word;

    // Write FSM next state: a frame only starts into an empty bank, otherwise it is dropped whole.
    always_comb begin
        w_wstate_nxt = r_wstate;
        w_wr_ptr_nxt = r_wr_ptr;
        w_we         = 1'b0;
        w_set_full   = 1'b0;
        w_ferr       = 1'b0;
        w_ovf_set    = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                if (r_cap_en) begin
                    if (!r_full[r_wr_bank]) begin
                        w_we         = 1'b1;
                        w_wr_ptr_nxt = PTR_ONE;
                        w_wstate_nxt = W_FILL;
                    end else begin
                        w_ovf_set    = 1'b1;
                        w_wstate_nxt = W_DROP;
                    end
                end else begin
                    w_wr_ptr_nxt = PTR_ZERO;
                end
            end
            W_FILL: begin
                if (r_cap_en) begin
                    w_we = 1'b1;
                    if (r_wr_ptr == PTR_LAST) begin
                        w_set_full   = 1'b1;
                        w_wr_ptr_nxt = PTR_ZERO;
                        w_wstate_nxt = W_IDLE;
                    end else begin
                        w_wr_ptr_nxt = r_wr_ptr + PTR_ONE;
                    end
                end else begin
                    w_ferr       = 1'b1;
                    w_wr_ptr_nxt = PTR_ZERO;
                    w_wstate_nxt = W_IDLE;
                end
            end
            W_DROP: begin
                if (!r_cap_en) begin
                    w_wstate_nxt = W_IDLE;
                end else begin
                    w_wstate_nxt = W_DROP;
                end
            end
            default: begin
                w_wr_ptr_nxt = PTR_ZERO;
                w_wstate_nxt = W_IDLE;
            end
        endcase
    end

    // Write-side state, input alignment and status flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cap_en    <= 1'b0;
            r_wstate    <= W_IDLE;
            r_wr_ptr    <= PTR_ZERO;
            r_wr_bank   <= 1'b0;
            r_frame_err <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_cap_en    <= sol_valid;
            r_wstate    <= w_wstate_nxt;
            r_wr_ptr    <= w_wr_ptr_nxt;
            r_wr_bank   <= r_wr_bank ^ w_set_full;
            r_frame_err <= w_ferr;
            r_overflow  <= r_overflow | w_ovf_set;
        end
    end

    // Frame storage; bank validity is tracked by r_full, so the array itself needs no reset.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[r_wr_bank][r_wr_ptr] <= sol_data;
        end
    end

    // Writer only ever fills, and reader only ever drains, the bank it currently owns.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_full <= 2'b00;
        end else begin
            r_full <= (r_full | (w_set_full ? (2'b01 << r_wr_bank) : 2'b00))
                      & ~(w_clr_full ? (2'b01 << r_rd_bank) : 2'b00);
        end
    end

    assign w_xfer = r_out_valid & out_ready;

    // Read FSM next state: preload the next word into the output flops on every accepted beat.
    always_comb begin
        w_rstate_nxt  = r_rstate;
        w_rd_bank_nxt = r_rd_bank;
        w_load        = 1'b0;
        w_load_bank   = r_rd_bank;
        w_load_ptr    = r_rd_ptr;
        w_clr_full    = 1'b0;
        w_cnt_inc     = 1'b0;
        w_valid_nxt   = r_out_valid;
        case (r_rstate)
            R_IDLE: begin
                if (r_full[r_rd_bank]) begin
                    w_load       = 1'b1;
                    w_load_ptr   = PTR_ZERO;
                    w_valid_nxt  = 1'b1;
                    w_rstate_nxt = R_SEND;
                end else begin
                    w_valid_nxt  = 1'b0;
                end
            end
            R_SEND: begin
                if (w_xfer) begin
                    if (r_rd_ptr == PTR_LAST) begin
                        w_clr_full    = 1'b1;
                        w_cnt_inc     = 1'b1;
                        w_rd_bank_nxt = ~r_rd_bank;
                        if (r_full[~r_rd_bank]) begin
                            w_load       = 1'b1;
                            w_load_bank  = ~r_rd_bank;
                            w_load_ptr   = PTR_ZERO;
                            w_valid_nxt  = 1'b1;
                            w_rstate_nxt = R_SEND;
                        end else begin
                            w_valid_nxt  = 1'b0;
                            w_rstate_nxt = R_IDLE;
                        end
                    end else begin
                        w_load     = 1'b1;
                        w_load_ptr = r_rd_ptr + PTR_ONE;
                    end
                end else begin
                    w_valid_nxt = 1'b1;
                end
            end
            default: begin
                w_valid_nxt  = 1'b0;
                w_rstate_nxt = R_IDLE;
            end
        endcase
    end

    assign w_rd_word  = r_mem[w_load_bank][w_load_ptr];
    assign w_fmt_word = ROUND_EN ? round_q16(w_rd_word) : w_rd_word;

    // Read-side state and registered output stream.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rstate    <= R_IDLE;
            r_rd_bank   <= 1'b0;
            r_rd_ptr    <= PTR_ZERO;
            r_out_valid <= 1'b0;
            r_out_data  <= {DW{1'b0}};
            r_out_last  <= 1'b0;
            r_frame_cnt <= 8'd0;
        end else begin
            r_rstate    <= w_rstate_nxt;
            r_rd_bank   <= w_rd_bank_nxt;
            r_out_valid <= w_valid_nxt;
            r_frame_cnt <= r_frame_cnt + {7'd0, w_cnt_inc};
            if (w_load) begin
                r_rd_ptr   <= w_load_ptr;
                r_out_data <= w_fmt_word;
                r_out_last <= (w_load_ptr == PTR_LAST);
            end else if (!w_valid_nxt) begin
                r_rd_ptr   <= PTR_ZERO;
                r_out_last <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_idx   = r_rd_ptr;
    assign out_last  = r_out_last;
    assign frame_cnt = r_frame_cnt;
    assign overflow  = r_overflow;
    assign frame_err = r_frame_err;

endmodule

// File: tb/tb_gsim_result_buffer.sv
// Directed bench for gsim_result_buffer: raw instance plus a ROUND_EN=1 instance for rounding checks.
module tb_gsim_result_buffer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    always #5 clk = ~clk;

    logic        sol_valid, out_valid, out_ready, out_last, overflow, frame_err;
    logic [31:0] sol_data, out_data;
    logic [3:0]  out_idx;
    logic [7:0]  frame_cnt;

    logic        sv_r, ov_r, or_r, ol_r, of_r, fe_r;
    logic [31:0] sd_r, od_r;
    logic [3:0]  oi_r;
    logic [7:0]  fc_r;

    gsim_result_buffer #(.N_WORDS(16), .DW(32), .ROUND_EN(1'b0)) dut (
        .clk(clk), .reset(reset), .sol_valid(sol_valid), .sol_data(sol_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
        .out_last(out_last), .frame_cnt(frame_cnt), .overflow(overflow), .frame_err(frame_err));

    gsim_result_buffer #(.N_WORDS(16), .DW(32), .ROUND_EN(1'b1)) dut_rnd (
        .clk(clk), .reset(reset), .sol_valid(sv_r), .sol_data(sd_r),
        .out_valid(ov_r), .out_ready(or_r), .out_data(od_r), .out_idx(oi_r),
        .out_last(ol_r), .frame_cnt(fc_r), .overflow(of_r), .frame_err(fe_r));

    int total = 0;
    int bad = 0;
    int ferr_cnt = 0;
    logic [31:0] tx [16];
    logic [31:0] ex [16];

    always @(negedge clk) if (frame_err) ferr_cnt++;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic fill(input logic [31:0] base, input logic [31:0] step);
        for (int i = 0; i < 16; i++) begin
            tx[i] = base + step * 32'(i);
            ex[i] = tx[i];
        end
    endtask

    // Word k appears on sol_data the cycle after its sol_valid cycle.
    task automatic burst(input int n, input bit sel);
        for (int k = 0; k <= n; k++) begin
            if (sel) begin
                sv_r = (k < n);
                if (k >= 1) sd_r = tx[k-1];
            end else begin
                sol_valid = (k < n);
                if (k >= 1) sol_data = tx[k-1];
            end
            tick();
        end
    endtask

    task automatic recv(input bit sel, input bit stall, input string tag);
        int b;
        int cyc;
        logic rdy, v, l;
        logic [31:0] d;
        logic [3:0] ix;
        b = 0;
        cyc = 0;
        while (b < 16 && cyc < 200) begin
            rdy = stall ? (cyc % 3 == 0) : 1'b1;
            if (sel) or_r = rdy; else out_ready = rdy;
            v  = sel ? ov_r : out_valid;
            d  = sel ? od_r : out_data;
            ix = sel ? oi_r : out_idx;
            l  = sel ? ol_r : out_last;
            if (v) begin
                chk({tag, "_idx"}, 32'(ix), 32'(b));
                chk({tag, "_data"}, d, ex[b]);
                chk({tag, "_last"}, 32'(l), 32'(b == 15));
                if (rdy) b++;
            end
            tick();
            cyc++;
        end
        chk({tag, "_beats"}, 32'(b), 32'd16);
    endtask

    initial begin
        int g;
        sol_valid = 1'b0; sol_data = 32'd0; out_ready = 1'b0;
        sv_r = 1'b0; sd_r = 32'd0; or_r = 1'b0;
        reset = 1'b1;
        tick(); tick();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_idx", 32'(out_idx), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_cnt", 32'(frame_cnt), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_ferr", 32'(frame_err), 32'd0);
        reset = 1'b0;
        tick();

        // T1: single frame, consumer always ready, latency check
        fill(32'h0000_0000, 32'h0001_0000);
        out_ready = 1'b1;
        burst(16, 1'b0);
        chk("t1_lat0", 32'(out_valid), 32'd0);
        tick();
        chk("t1_lat1", 32'(out_valid), 32'd1);
        recv(1'b0, 1'b0, "t1");
        chk("t1_idle", 32'(out_valid), 32'd0);
        chk("t1_cnt", 32'(frame_cnt), 32'd1);

        // T2: backpressure pattern 1,0,0,...
        fill(32'hA000_0000, 32'h0000_0101);
        out_ready = 1'b0;
        burst(16, 1'b0);
        recv(1'b0, 1'b1, "t2");
        chk("t2_idle", 32'(out_valid), 32'd0);
        chk("t2_cnt", 32'(frame_cnt), 32'd2);

        // T3: three frames while stalled; third is dropped
        out_ready = 1'b0;
        fill(32'h1000_0000, 32'h0000_0001);
        burst(16, 1'b0);
        fill(32'h2000_0000, 32'h0000_0002);
        burst(16, 1'b0);
        chk("t3_ovf0", 32'(overflow), 32'd0);
        fill(32'h3000_0000, 32'h0000_0003);
        burst(16, 1'b0);
        tick();
        chk("t3_ovf1", 32'(overflow), 32'd1);
        chk("t3_ferr", 32'(ferr_cnt), 32'd0);
        chk("t3_held_idx", 32'(out_idx), 32'd0);
        fill(32'h1000_0000, 32'h0000_0001);
        recv(1'b0, 1'b0, "t3a");
        fill(32'h2000_0000, 32'h0000_0002);
        recv(1'b0, 1'b0, "t3b");
        chk("t3_idle", 32'(out_valid), 32'd0);
        chk("t3_cnt", 32'(frame_cnt), 32'd4);

        // T4: short burst of 9 words, then a full frame
        out_ready = 1'b1;
        fill(32'h0ABC_0000, 32'h0000_0003);
        burst(9, 1'b0);
        tick(); tick(); tick(); tick();
        chk("t4_ferr", 32'(ferr_cnt), 32'd1);
        chk("t4_novalid", 32'(out_valid), 32'd0);
        chk("t4_cnt0", 32'(frame_cnt), 32'd4);
        chk("t4_ovf_sticky", 32'(overflow), 32'd1);
        fill(32'h5555_0000, 32'h0000_0011);
        burst(16, 1'b0);
        recv(1'b0, 1'b0, "t4");
        chk("t4_cnt", 32'(frame_cnt), 32'd5);

        // T5: rounding instance
        for (int i = 0; i < 16; i++) begin
            tx[i] = 32'(i) << 16;
            ex[i] = 32'(i);
        end
        tx[0] = 32'h0002_8000; ex[0] = 32'h0000_0003;
        tx[1] = 32'h0002_7FFF; ex[1] = 32'h0000_0002;
        tx[2] = 32'hFFFF_8000; ex[2] = 32'h0000_0000;
        tx[3] = 32'h7FFF_FFFF; ex[3] = 32'h0000_8000;
        tx[4] = 32'h8000_0000; ex[4] = 32'hFFFF_8000;
        tx[5] = 32'hFFFE_8000; ex[5] = 32'hFFFF_FFFF;
        tx[6] = 32'hFFFF_7FFF; ex[6] = 32'hFFFF_FFFF;
        tx[7] = 32'h0000_0000; ex[7] = 32'h0000_0000;
        burst(16, 1'b1);
        recv(1'b1, 1'b0, "t5");
        chk("t5_cnt", 32'(fc_r), 32'd1);

        // T6: reset while sending index 7
        fill(32'h0777_0000, 32'h0001_0000);
        out_ready = 1'b1;
        burst(16, 1'b0);
        g = 0;
        while (!(out_valid && out_idx == 4'd7) && g < 60) begin
            tick();
            g++;
        end
        chk("t6_at7", 32'(out_idx), 32'd7);
        reset = 1'b1;
        tick();
        chk("t6_valid", 32'(out_valid), 32'd0);
        chk("t6_data", out_data, 32'd0);
        chk("t6_idx", 32'(out_idx), 32'd0);
        chk("t6_last", 32'(out_last), 32'd0);
        chk("t6_cnt0", 32'(frame_cnt), 32'd0);
        chk("t6_ovf", 32'(overflow), 32'd0);
        reset = 1'b0;
        tick();
        fill(32'h1234_0000, 32'h0001_0001);
        burst(16, 1'b0);
        recv(1'b0, 1'b0, "t6");
        chk("t6_cnt", 32'(frame_cnt), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
